// File: rtl/backprop_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : backprop_seq_if
// Description : Bundles the sequencer's sample-memory handshake, datapath
//               controls/bus and parameter-memory write port.
//               master : sequencer side (drives requests and strobes)
//               slave  : memory/datapath side (drives smp_ack, bus_in)
// Ports       : smp_req/smp_addr/smp_ack  - sample fetch handshake
//               dp_rst/dp_we/dp_dtb/bus_in - backprop datapath control/bus
//               pm_we/pm_addr/pm_wdata     - parameter memory write port
// Revision    : 1.0 - initial release
// ============================================================================
interface backprop_seq_if #(
   parameter int N   = 32,
   parameter int NW  = 17,
   parameter int SAW = 4
);
   localparam int AW = $clog2(NW);

   logic             smp_req;
   logic [SAW-1:0]   smp_addr;
   logic             smp_ack;

   logic             dp_rst;
   logic [NW-1:0]    dp_we;
   logic             dp_dtb;
   logic [2*N-1:0]   bus_in;

   logic             pm_we;
   logic [AW-1:0]    pm_addr;
   logic [N-1:0]     pm_wdata;

   modport master (
      output smp_req, smp_addr, dp_rst, dp_we, dp_dtb, pm_we, pm_addr, pm_wdata,
      input  smp_ack, bus_in
   );

   modport slave (
      input  smp_req, smp_addr, dp_rst, dp_we, dp_dtb, pm_we, pm_addr, pm_wdata,
      output smp_ack, bus_in
   );
endinterface
`default_nettype wire

// File: rtl/backprop_seq.sv
`default_nettype none
// ============================================================================
// Module      : backprop_seq
// Description : Sequencer for the batch back-propagation datapath. Runs
//               `epochs` epochs of `batch` samples: fetch sample, wait for
//               the forward pass to settle, pulse accumulation, and at batch
//               end walk the one-hot write-back into parameter memory.
// Ports       : clk, rst (async, active-low)
//               start/epochs/batch        - job request and operands
//               busy/done/epoch_cnt       - job status
//               bus_if (master)           - sample, datapath, param memory
// Revision    : 1.0 - initial release
// ============================================================================
module backprop_seq #(
   parameter int N       = 32,
   parameter int NW      = 17,
   parameter int SAW     = 4,
   parameter int FWD_LAT = 2,
   parameter int EW      = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [EW-1:0]   epochs,
   input  logic [SAW:0]    batch,
   output logic            busy,
   output logic            done,
   output logic [EW-1:0]   epoch_cnt,
   backprop_seq_if.master  bus_if
);

   localparam int AW  = $clog2(NW);
   localparam int SCW = (FWD_LAT > 0) ? $clog2(FWD_LAT + 1) : 1;
   localparam logic [NW-1:0] WE_MSB = {1'b1, {(NW-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FETCH, S_SETTLE, S_ACCUM, S_WRITE, S_NEXT, S_DONE
   } state_t;

   state_t           state_q,     state_d;
   logic [SAW-1:0]   idx_q,       idx_d;
   logic [AW-1:0]    k_q,         k_d;
   logic [SCW-1:0]   settle_q,    settle_d;
   logic [EW-1:0]    epoch_cnt_q, epoch_cnt_d;
   logic [EW-1:0]    epochs_q,    epochs_d;
   logic [SAW:0]     batch_q,     batch_d;

   // Registered outputs, decoded from the next-state values
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;
   logic             smp_req_q,  smp_req_d;
   logic [SAW-1:0]   smp_addr_q, smp_addr_d;
   logic             dp_rst_q,   dp_rst_d;
   logic [NW-1:0]    dp_we_q,    dp_we_d;
   logic             dp_dtb_q,   dp_dtb_d;
   logic             pm_we_q,    pm_we_d;
   logic [AW-1:0]    pm_addr_q,  pm_addr_d;

   // Only the low word of the datapath bus carries parameter data
   logic             unused_bus_hi;
   assign unused_bus_hi = ^bus_if.bus_in[2*N-1:N];

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      k_d         = k_q;
      settle_d    = settle_q;
      epoch_cnt_d = epoch_cnt_q;
      epochs_d    = epochs_q;
      batch_d     = batch_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               epoch_cnt_d = '0;
               if (epochs != '0 && batch != '0) begin
                  epochs_d = epochs;
                  batch_d  = batch;
                  state_d  = S_CLEAR;
               end else begin
                  // Empty job: report completion without touching memories
                  state_d = S_DONE;
               end
            end
         end
         S_CLEAR: begin
            idx_d   = '0;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (bus_if.smp_ack) begin
               if (FWD_LAT == 0) begin
                  state_d = S_ACCUM;
               end else begin
                  settle_d = SCW'(FWD_LAT);
                  state_d  = S_SETTLE;
               end
            end
         end
         S_SETTLE: begin
            settle_d = settle_q - 1'b1;
            if (settle_q == SCW'(1)) begin
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if ({1'b0, idx_q} == batch_q - 1'b1) begin
               k_d     = '0;
               state_d = S_WRITE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_FETCH;
            end
         end
         S_WRITE: begin
            if (k_q == AW'(NW - 1)) begin
               state_d = S_NEXT;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_NEXT: begin
            epoch_cnt_d = epoch_cnt_q + 1'b1;
            state_d     = (epoch_cnt_d == epochs_q) ? S_DONE : S_CLEAR;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      dp_rst_d   = (state_d == S_IDLE) || (state_d == S_CLEAR);
      smp_req_d  = (state_d == S_FETCH);
      smp_addr_d = (state_d == S_FETCH) ? idx_d : '0;
      dp_dtb_d   = (state_d == S_WRITE);
      pm_we_d    = (state_d == S_WRITE);
      pm_addr_d  = (state_d == S_WRITE) ? k_d : '0;
      // All-ones only in ACCUM (dtb=0); a single bit in WRITE, so the bus
      // never has more than one driver.
      if (state_d == S_ACCUM) begin
         dp_we_d = '1;
      end else if (state_d == S_WRITE) begin
         dp_we_d = WE_MSB >> k_d;
      end else begin
         dp_we_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         k_q         <= '0;
         settle_q    <= '0;
         epoch_cnt_q <= '0;
         epochs_q    <= '0;
         batch_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         smp_req_q   <= 1'b0;
         smp_addr_q  <= '0;
         dp_rst_q    <= 1'b1;
         dp_we_q     <= '0;
         dp_dtb_q    <= 1'b0;
         pm_we_q     <= 1'b0;
         pm_addr_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         k_q         <= k_d;
         settle_q    <= settle_d;
         epoch_cnt_q <= epoch_cnt_d;
         epochs_q    <= epochs_d;
         batch_q     <= batch_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         smp_req_q   <= smp_req_d;
         smp_addr_q  <= smp_addr_d;
         dp_rst_q    <= dp_rst_d;
         dp_we_q     <= dp_we_d;
         dp_dtb_q    <= dp_dtb_d;
         pm_we_q     <= pm_we_d;
         pm_addr_q   <= pm_addr_d;
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign epoch_cnt        = epoch_cnt_q;
   assign bus_if.smp_req   = smp_req_q;
   assign bus_if.smp_addr  = smp_addr_q;
   assign bus_if.dp_rst    = dp_rst_q;
   assign bus_if.dp_we     = dp_we_q;
   assign bus_if.dp_dtb    = dp_dtb_q;
   assign bus_if.pm_we     = pm_we_q;
   assign bus_if.pm_addr   = pm_addr_q;
   // Write data passes straight through, gated so it reads zero (and dies
   // with the strobe on reset) outside a write cycle.
   assign bus_if.pm_wdata  = pm_we_q ? bus_if.bus_in[N-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_backprop_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_backprop_seq
// Description : Self-checking bench for backprop_seq. Instance dut uses
//               FWD_LAT=2 with a programmable-delay sample memory; instance
//               dut0 uses FWD_LAT=0 with ack tied high.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_backprop_seq;
   localparam int N = 32, NW = 17, SAW = 4, EW = 16, FWD = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start, start0;
   logic [EW-1:0] epochs, epochs0, epoch_cnt, epoch_cnt0;
   logic [SAW:0]  batch, batch0;
   logic busy, done, busy0, done0;

   backprop_seq_if #(.N(N), .NW(NW), .SAW(SAW)) bif ();
   backprop_seq_if #(.N(N), .NW(NW), .SAW(SAW)) bif0 ();

   backprop_seq #(.N(N), .NW(NW), .SAW(SAW), .FWD_LAT(FWD), .EW(EW)) dut (
      .clk(clk), .rst(rst_n), .start(start), .epochs(epochs), .batch(batch),
      .busy(busy), .done(done), .epoch_cnt(epoch_cnt), .bus_if(bif));

   backprop_seq #(.N(N), .NW(NW), .SAW(SAW), .FWD_LAT(0), .EW(EW)) dut0 (
      .clk(clk), .rst(rst_n), .start(start0), .epochs(epochs0), .batch(batch0),
      .busy(busy0), .done(done0), .epoch_cnt(epoch_cnt0), .bus_if(bif0));

   int tests = 0, fails = 0;

   task automatic check_int(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Datapath model: the register selected by a one-hot write enable in bus
   // mode drives word k = NW-1-bit onto the low half; the high half is junk.
   function automatic logic [2*N-1:0] dp_bus(input logic [NW-1:0] we, input logic dtb);
      logic [N-1:0] lo = 32'hFFFF_FFFF;
      if (dtb && $onehot(we))
         for (int p = 0; p < NW; p++)
            if (we[p]) lo = 32'h0001_0000 + 32'(NW - 1 - p);
      return {32'hDEAD_BEEF, lo};
   endfunction

   always_comb bif.bus_in  = dp_bus(bif.dp_we, bif.dp_dtb);
   always_comb bif0.bus_in = dp_bus(bif0.dp_we, bif0.dp_dtb);
   assign bif0.smp_ack = 1'b1;

   // Sample memory for dut: fetch f is acknowledged after delays[f] cycles
   int delays [64];
   int fetch_no, wait_cnt;
   always @(negedge clk) begin
      if (!busy) begin
         fetch_no = 0; wait_cnt = 0; bif.smp_ack = 1'b0;
      end else if (bif.smp_req) begin
         bif.smp_ack = (wait_cnt >= delays[fetch_no]);
         wait_cnt++;
      end else begin
         if (bif.smp_ack) fetch_no++;
         wait_cnt = 0; bif.smp_ack = 1'b0;
      end
   end

   // Observer for dut: records what happened during a job
   int obs_accum, obs_pmwe, obs_clear, mon_viol, exp_k, reqlen;
   int obs_addr[$], obs_reqlen[$], obs_ep[$];
   logic prev_req;
   logic [SAW-1:0] prev_addr;
   logic [EW-1:0] prev_ep;
   logic [NW-1:0] exp_we;
   always @(negedge clk) begin
      if (!busy) begin
         obs_accum = 0; obs_pmwe = 0; obs_clear = 0; mon_viol = 0; exp_k = 0; reqlen = 0;
         obs_addr.delete(); obs_reqlen.delete(); obs_ep.delete();
         prev_req = 1'b0; prev_addr = '0; prev_ep = '0;
      end else begin
         if (bif.dp_we == '1) begin
            if (bif.dp_dtb) mon_viol++; else obs_accum++;
         end
         if (bif.pm_we) begin
            obs_pmwe++;
            exp_we = '0; exp_we[NW-1-exp_k] = 1'b1;
            if (int'(bif.pm_addr) != exp_k || bif.dp_we != exp_we || !bif.dp_dtb ||
                bif.pm_wdata != 32'h0001_0000 + 32'(exp_k)) mon_viol++;
            exp_k = (exp_k == NW - 1) ? 0 : exp_k + 1;
         end else begin
            if (bif.dp_we != '0 && bif.dp_we != '1) mon_viol++;
            if (bif.pm_addr != '0 || bif.pm_wdata != '0 || bif.dp_dtb) mon_viol++;
         end
         if (bif.dp_rst) obs_clear++;
         if (bif.smp_req && !prev_req) begin
            obs_addr.push_back(int'(bif.smp_addr)); reqlen = 1;
         end else if (bif.smp_req) begin
            reqlen++;
            if (bif.smp_addr != prev_addr) mon_viol++;
         end else if (prev_req) begin
            obs_reqlen.push_back(reqlen);
         end
         if (epoch_cnt != prev_ep) obs_ep.push_back(int'(epoch_cnt));
         prev_req = bif.smp_req; prev_addr = bif.smp_addr; prev_ep = epoch_cnt;
      end
   end

   function automatic bit q_eq(input int a[$], input int b[$]);
      if (a.size() != b.size()) return 1'b0;
      foreach (a[i]) if (a[i] != b[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Reference job length from the rules: CLEAR + per sample (wait+1 FETCH,
   // FWD settle, 1 ACCUM) + NW writes + NEXT per epoch, then the DONE cycle.
   function automatic int model_cycles(input int e, input int b);
      int tot;
      if (e == 0 || b == 0) return 1;
      tot = e * (NW + 2) + 1;
      for (int f = 0; f < e * b; f++) tot += delays[f] + 2 + FWD;
      return tot;
   endfunction

   task automatic start_job(input int e, input int b);
      @(negedge clk);
      epochs = EW'(e); batch = (SAW+1)'(b); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_job(input int e, input int b, input bit poke, output int cyc);
      int exp_addr[$], exp_len[$], exp_ep[$];
      bit got = 0, valid = (e != 0 && b != 0);
      if (valid) begin
         for (int ep = 0; ep < e; ep++)
            for (int i = 0; i < b; i++) begin
               exp_addr.push_back(i); exp_len.push_back(delays[ep * b + i] + 1);
            end
         for (int ep = 1; ep <= e; ep++) exp_ep.push_back(ep);
      end
      start_job(e, b);
      cyc = 0;
      while (!got && cyc < 3000) begin
         @(negedge clk); #1; cyc++;
         if (poke && cyc == 8) begin start = 1'b1; epochs = 5; batch = 3; end
         if (poke && cyc == 9) start = 1'b0;
         if (done) got = 1;
      end
      check_int("done_seen", 64'(got), 1);
      check_int("accum_pulses", 64'(obs_accum), valid ? 64'(e * b) : 0);
      check_int("pm_we_cycles", 64'(obs_pmwe), valid ? 64'(e * NW) : 0);
      check_int("clear_pulses", 64'(obs_clear), valid ? 64'(e) : 0);
      check_int("protocol_viol", 64'(mon_viol), 0);
      check_int("smp_addr_seq", 64'(q_eq(obs_addr, exp_addr)), 1);
      check_int("smp_req_hold", 64'(q_eq(obs_reqlen, exp_len)), 1);
      check_int("epoch_cnt_steps", 64'(q_eq(obs_ep, exp_ep)), 1);
      check_int("epoch_cnt_final", 64'(epoch_cnt), valid ? 64'(e) : 0);
      @(negedge clk); #1;
      check_int("done_pulse_idle", 64'({done, busy}), 0);
   endtask

   typedef struct { int e; int b; int exp_cyc; } vec_t;
   vec_t tbl [6];
   int cyc, rb, re, got, kk, pm_ok, follow, bad;
   logic prev0;

   initial begin
      tbl[0] = '{1, 4, 36};   tbl[1] = '{3, 1, 70};  tbl[2] = '{2, 16, 167};
      tbl[3] = '{0, 5, 1};    tbl[4] = '{4, 0, 1};   tbl[5] = '{1, 1, 24};
      foreach (delays[i]) delays[i] = 0;
      start = 0; epochs = 0; batch = 0; start0 = 0; epochs0 = 0; batch0 = 0;
      rst_n = 1'b1; #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check_int("reset_dp_rst", 64'(bif.dp_rst), 1);
      check_int("reset_status", 64'({busy, done, epoch_cnt}), 0);
      check_int("reset_bus", 64'({bif.smp_req, bif.smp_addr, bif.dp_we, bif.dp_dtb,
                                  bif.pm_we, bif.pm_addr, bif.pm_wdata}), 0);
      @(negedge clk); rst_n = 1'b1;

      // Table-driven jobs, ack immediate
      foreach (tbl[i]) begin
         run_job(tbl[i].e, tbl[i].b, 1'b0, cyc);
         check_int($sformatf("tbl%0d_cycles", i), 64'(cyc), 64'(tbl[i].exp_cyc));
      end

      // Ack delayed 3 cycles on sample 2: epoch 3 cycles longer
      delays[2] = 3;
      run_job(1, 4, 1'b0, cyc);
      check_int("dly_ack_cycles", 64'(cyc), 39);
      delays[2] = 0;

      // start/operand changes while busy must not disturb the job
      run_job(2, 3, 1'b1, cyc);
      check_int("busy_start_cycles", 64'(cyc), 63);

      // Randomized jobs against the reference model
      for (int r = 0; r < 6; r++) begin
         re = $urandom_range(1, 3); rb = $urandom_range(1, 16);
         foreach (delays[i]) delays[i] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
         run_job(re, rb, 1'b0, cyc);
         check_int($sformatf("rand%0d_cycles", r), 64'(cyc), 64'(model_cycles(re, rb)));
      end
      foreach (delays[i]) delays[i] = 0;

      // Reset asserted mid-WRITE at k=5
      start_job(1, 1);
      got = 0; cyc = 0;
      while (!got && cyc < 100) begin
         @(negedge clk); #1; cyc++;
         if (bif.pm_we && bif.pm_addr == 5) got = 1;
      end
      check_int("rst_reach_k5", 64'(got), 1);
      rst_n = 1'b0; #1;
      check_int("rst_pm_we", 64'(bif.pm_we), 0);
      check_int("rst_dp_rst", 64'(bif.dp_rst), 1);
      check_int("rst_outputs", 64'({busy, done, epoch_cnt, bif.smp_req, bif.smp_addr,
                                    bif.dp_we, bif.dp_dtb, bif.pm_addr}), 0);
      check_int("rst_pm_wdata", 64'(bif.pm_wdata), 0);
      @(negedge clk); rst_n = 1'b1;
      run_job(1, 1, 1'b0, cyc);
      check_int("after_rst_cycles", 64'(cyc), 24);

      // FWD_LAT=0 instance: ACCUM right after the ack cycle, data pass-through
      @(negedge clk); epochs0 = 1; batch0 = 2; start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      cyc = 0; got = 0; kk = 0; pm_ok = 0; follow = 0; bad = 0; prev0 = 1'b0;
      while (!got && cyc < 200) begin
         @(negedge clk); #1; cyc++;
         if (bif0.dp_we == '1 && !bif0.dp_dtb) begin
            if (prev0) follow++; else bad++;
         end else if (prev0) bad++;
         if (bif0.pm_we) begin
            if (int'(bif0.pm_addr) == kk && bif0.pm_wdata == 32'h0001_0000 + 32'(kk)) pm_ok++;
            kk++;
         end
         prev0 = bif0.smp_req;   // ack tied high: every request cycle is an ack cycle
         if (done0) got = 1;
      end
      check_int("fl0_cycles", 64'(cyc), 24);
      check_int("fl0_accum_follow", 64'(follow), 2);
      check_int("fl0_accum_bad", 64'(bad), 0);
      check_int("fl0_pm_wdata", 64'(pm_ok), NW);
      check_int("fl0_pm_count", 64'(kk), NW);
      check_int("fl0_epoch_cnt", 64'(epoch_cnt0), 1);
      @(negedge clk); #1;
      check_int("fl0_idle", 64'(busy0), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/backprop_seq.md
# backprop_seq

Sequencer for the batch back-propagation datapath. It runs a training job of `epochs` epochs with `batch` samples each:
- fetches each sample from sample memory;
- waits for the forward pass to settle, then pulses accumulation of the weight/bias deltas and cost;
- at batch end, walks the one-hot write-back over every parameter word and stores each updated value into parameter memory.

It sits between the host/start logic, the sample memory, the backprop datapath (`we`, `dtb`, `rst`, `bus`) and the parameter memory.

## Interface
Parameters:
- `N`, 32, fixed-point word width (matches the `n` define).
- `NW`, 17, total parameter words (weights + biases); width of `dp_we`.
- `SAW`, 4, sample address width; maximum batch is 2^SAW.
- `FWD_LAT`, 2, settle cycles after a sample is presented (0 allowed).
- `EW`, 16, epoch counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: job request, sampled in IDLE only.
- `epochs` in EW: epoch count, latched on start.
- `batch` in SAW+1: samples per epoch (1..2^SAW), latched on start.
- `busy` out 1: high from the cycle after start acceptance through DONE.
- `done` out 1: one-cycle pulse at job end.
- `epoch_cnt` out EW: completed epochs in the current job.
- `smp_req` out 1: sample request, held until ack.
- `smp_addr` out SAW: sample index, stable while `smp_req` is high.
- `smp_ack` in 1: sample memory has driven `nx`/`lt` for `smp_addr`; the data stays valid until the next `smp_req`.
- `dp_rst` out 1: active-high synchronous clear to the datapath accumulators.
- `dp_we` out NW: datapath write enables.
- `dp_dtb` out 1: datapath mode; 0 = accumulate, 1 = drive bus.
- `bus_in` in 2N: datapath bus.
- `pm_we` out 1: parameter memory write strobe.
- `pm_addr` out clog2(NW): parameter memory address.
- `pm_wdata` out N: parameter memory write data.

## Operation
- States: IDLE, CLEAR, FETCH, SETTLE, ACCUM, WRITE, NEXT, DONE.
- IDLE:
  - `dp_rst`=1; all other outputs 0.
  - `start`=1 with `epochs`≠0 and `batch`≠0: latch both operands, clear `epoch_cnt`, go to CLEAR.
  - `start`=1 with a zero operand: go straight to DONE; no sample or bus activity.
- CLEAR: `dp_rst`=1 for one cycle; sample index := 0; go to FETCH.
- FETCH:
  - `smp_req`=1, `smp_addr`=index.
  - On `smp_ack`=1 go to SETTLE, loading the settle counter with FWD_LAT.
  - If FWD_LAT=0, go directly to ACCUM.
- SETTLE: decrement the settle counter; go to ACCUM when it reaches 0 (FWD_LAT cycles spent here).
- ACCUM:
  - One cycle with `dp_we`=all ones and `dp_dtb`=0. This enables every delta register and the cost register, whose enable is `we[NW-1]&we[0]`.
  - If index = batch−1, go to WRITE with word counter k := 0.
  - Otherwise increment index and go to FETCH.
- WRITE, NW cycles, k = 0..NW−1:
  - `dp_dtb`=1.
  - `dp_we` is one-hot at bit NW−1−k.
  - `pm_we`=1, `pm_addr`=k, `pm_wdata`=`bus_in[N-1:0]`, passed combinationally.
  - `dp_dtb`=1 also clears the datapath cost register.
  - After k = NW−1, go to NEXT.
- NEXT:
  - Increment `epoch_cnt`.
  - If it now equals the latched `epochs`, go to DONE; otherwise go to CLEAR.
- DONE: `done`=1 for one cycle, then IDLE.
- `dp_we` is all-zero in every state except ACCUM and WRITE.
- `dp_we` is never all-ones while `dp_dtb`=1, which prevents bus contention.
- `start` is ignored while busy. Changes to `epochs`/`batch` mid-job have no effect.
- `smp_ack` is ignored outside FETCH.
- Asserting `rst` low mid-job immediately returns all state and outputs to their reset values. No partial parameter write completes after reset assertion.

## Timing
- Reset values: IDLE, `dp_rst`=1, `epoch_cnt`=0, every other output 0.
- Start acceptance is edge E. CLEAR is active in cycle E+1, and `busy` rises at E+1.
- Per sample: FETCH wait (≥1 cycle; exactly 1 if `smp_ack` is already high) + FWD_LAT + 1 ACCUM cycle.
- Epoch length with immediate ack: 1 + batch·(2+FWD_LAT) + NW + 1 cycles.
- `done` occurs in the cycle after the final NEXT. `busy` falls with the return to IDLE.
- All outputs are registered except `pm_wdata`.
- `pm_addr` equals k, so word 0 holds the value driven under `we[NW-1]`.

## Test plan
- Reset mid-WRITE (k=5): all outputs return to reset values asynchronously; `pm_we` drops in the same cycle; the next start runs from CLEAR.
- batch=4, epochs=1, FWD_LAT=2, ack tied high:
  - exactly 4 ACCUM pulses;
  - `smp_addr` sequence 0,1,2,3;
  - 17 `pm_we` cycles with `pm_addr` 0..16 and `dp_we` walking 0x10000→0x00001;
  - `done` 36 cycles after start acceptance.
- Ack delayed 3 cycles on sample 2: `smp_req` and `smp_addr`=2 are held stable for 4 cycles, and the epoch is 3 cycles longer.
- epochs=3, batch=1: three CLEAR pulses on `dp_rst`; `epoch_cnt` steps 1, 2, 3; a single `done`.
- Zero operands: `epochs`=0 or `batch`=0 gives `done` at E+1 with no `smp_req` and no `pm_we`. `start` asserted while busy changes nothing.
- FWD_LAT=0, `bus_in` driven as a per-word pattern 0x0001_0000+k: `pm_wdata` matches the pattern for each k, and ACCUM directly follows the ack cycle.
